mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//   Multi-cycle control sequencer for the MIPS32 core datapath (PC, IR, shared instr/data memory, regfile, ALU).
//   Moore FSM; steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable and mux select.
//   Waits on the memory ready handshake with a bounded timeout; counts retired instructions.
//   Instantiated in the multi-cycle top beside the datapath; opcode/funct/zero come back from the datapath.
// PARAMETERS
//   TIMEOUT  16  max cycles to wait for mem_ready in a memory state before bus_err (>=2)
//   CNT_W    32  width of retired-instruction counter
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-low reset
//   opcode       in   6      IR[31:26], stable from DECODE until next FETCH
//   zero         in   1      ALU zero flag
//   mem_ready    in   1      memory completes the current read/write this cycle
//   pc_en        out  1      PC load enable
//   pc_src       out  2      00 ALU result, 01 ALUOut (branch target), 10 jump target
//   iord         out  1      memory address: 0 PC, 1 ALUOut
//   mem_read     out  1      memory read strobe
//   mem_write    out  1      memory write strobe
//   ir_write     out  1      IR load enable
//   reg_dst      out  1      dest reg: 0 rt, 1 rd
//   mem_to_reg   out  1      writeback: 0 ALUOut, 1 MDR
//   reg_write    out  1      regfile write enable
//   alu_src_a    out  1      0 PC, 1 reg A
//   alu_src_b    out  2      00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   alu_op       out  2      00 add, 01 sub, 10 funct-decoded, 11 or
//   bus_err      out  1      1-cycle pulse on memory timeout
//   illegal_op   out  1      1-cycle pulse on unknown opcode (in DECODE)
//   retired      out  CNT_W  retired-instruction count, wraps
//   state        out  4      current state (debug)
// BEHAVIOUR
//   Reset (rst=0, async): state=S_RESET, wait counter=0, retired=0; all outputs 0. First edge after release -> S_FETCH.
//   Unlisted outputs are 0 in every state. Values in a state are combinational from state (+mem_ready/zero/opcode where noted).
//   S_FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//     mem_ready=1: ir_write=1, pc_en=1 (same cycle) -> S_DECODE; else stay.
//   S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next by opcode:
//     000000 R -> S_EXEC; 100011 lw / 101011 sw -> S_MEMADR; 000100 beq / 000101 bne -> S_BRANCH;
//     001000 addi / 001101 ori -> S_IMMEX; 000010 j -> S_JUMP; other -> illegal_op=1, S_FETCH, no retire.
//   S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00 -> S_MEMRD (lw) / S_MEMWR (sw).
//   S_MEMRD: iord=1, mem_read=1; mem_ready -> S_MEMWB.   S_MEMWB: mem_to_reg=1, reg_dst=0, reg_write=1 -> S_FETCH, retire.
//   S_MEMWR: iord=1, mem_write=1; mem_ready -> S_FETCH, retire.
//   S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> S_ALUWB.   S_ALUWB: reg_dst=1, reg_write=1 -> S_FETCH, retire.
//   S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; pc_en = zero (beq) / ~zero (bne) -> S_FETCH, retire.
//   S_IMMEX: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) / 11 (ori) -> S_IMMWB.   S_IMMWB: reg_dst=0, reg_write=1 -> S_FETCH, retire.
//   S_JUMP: pc_src=10, pc_en=1 -> S_FETCH, retire.
//   Cycle counts: R/addi/ori 4, lw 5, sw 4, beq/bne 3, j 3 (zero-wait memory).
//   Wait counter: cleared on entry to each memory state (FETCH/MEMRD/MEMWR) and on mem_ready; increments per cycle without mem_ready.
//     Counter == TIMEOUT-1 and mem_ready=0: bus_err=1 that cycle, strobes still asserted, -> S_FETCH, no retire, no pc_en/ir_write.
//     FETCH timeout retries same PC. mem_ready in the timeout cycle wins (normal completion, no bus_err).
//   retire = registered +1 of retired on the transition into S_FETCH listed above; wraps 2^CNT_W-1 -> 0.
//   mem_ready outside memory states is ignored. Async reset mid-instruction aborts immediately; no partial retire.
//   Illegal state encodings -> S_FETCH next cycle.
// STRUCTURE
//   Package mips_mc_pkg: state encodings (S_RESET..S_JUMP), opcode constants, ALU_OP_* and PC_SRC_* codes, ALUB_* select codes.
//   Sub-module mc_wait_timer (clear, tick, expired at TIMEOUT-1) instantiated once; rest is one FSM + output decode.
// TESTING
//   Reset: rst=0 mid-S_MEMRD -> all outputs 0, retired=0 asynchronously; release -> S_FETCH after 1 edge.
//   R-type, mem_ready tied 1: opcode=000000 -> states FETCH,DECODE,EXEC,ALUWB; reg_dst=1,reg_write=1 in cycle 4; retired 0->1.
//   lw with 3 wait cycles on MEMRD -> mem_read,iord held 4 cycles, MEMWB mem_to_reg=1; total 8 cycles; retired +1.
//   beq zero=1 -> pc_en=1,pc_src=01 in BRANCH; bne zero=1 -> pc_en=0; both retire.
//   Timeout TIMEOUT=4, mem_ready=0 in FETCH -> bus_err pulse on 4th cycle, ir_write/pc_en never 1, back in FETCH, retired unchanged.
//   opcode=111111 -> illegal_op pulse in DECODE, next state FETCH, retired unchanged; retired wraps with CNT_W=4 after 16 j's.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multi-cycle MIPS32 control sequencer.
//   state_t      - controller state encodings (S_RESET..S_JUMP), 4 bits
//   OP_*         - primary opcode values (IR[31:26]) the controller decodes
//   ALU_OP_*     - alu_op codes sent to the ALU control block
//   PC_SRC_*     - pc_src mux select codes
//   ALUB_*       - alu_src_b mux select codes
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_OR    = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting on the memory handshake.
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-low reset
//   clear    in  force the count to 0 (wins over tick)
//   tick     in  advance the count by one
//   expired  out count has reached TIMEOUT-1
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (tick)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // The controller never ticks once expired, so the count cannot wrap.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: Moore control sequencer for the multi-cycle MIPS32 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath
// enables and mux selects, bounds memory waits and counts retired instructions.
//   clk, rst          clock / async active-low reset
//   opcode, zero      IR[31:26] and ALU zero flag from the datapath
//   mem_ready         memory completes the current access this cycle
//   pc_en, pc_src     PC load enable and source select
//   iord, mem_read, mem_write, ir_write       memory / IR controls
//   reg_dst, mem_to_reg, reg_write            regfile controls
//   alu_src_a, alu_src_b, alu_op              ALU operand / operation selects
//   bus_err, illegal_op                       1-cycle error pulses
//   retired                                   retired-instruction count (wraps)
//   state                                     current state (debug)
module mc_ctrl_fsm
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             bus_err,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             tmr_clear, tmr_tick, tmr_expired;

    mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .tick    (tmr_tick),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        // Timer is held clear everywhere except while a memory state is
        // still waiting; this also clears it on entry to every memory state.
        tmr_clear  = 1'b1;
        tmr_tick   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REG;
        alu_op     = ALU_OP_ADD;
        bus_err    = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmr_expired) begin
                    // PC not advanced, so the retry refetches the same address.
                    bus_err = 1'b1;
                end else begin
                    tmr_clear = 1'b0;
                    tmr_tick  = 1'b1;
                end
            end

            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                alu_src_b = ALUB_IMM_SH;
                case (opcode)
                    OP_RTYPE:        state_d = S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI, OP_ORI: state_d = S_IMMEX;
                    OP_J:            state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (tmr_expired) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    tmr_clear = 1'b0;
                    tmr_tick  = 1'b1;
                end
            end

            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (tmr_expired) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    tmr_clear = 1'b0;
                    tmr_tick  = 1'b1;
                end
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                pc_src    = PC_SRC_ALUOUT;
                // Only beq/bne reach here; bit 0 distinguishes them.
                pc_en     = (opcode == OP_BNE) ? ~zero : zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = (opcode == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
                state_d   = S_IMMWB;
            end

            S_IMMWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_JUMP: begin
                pc_src  = PC_SRC_JUMP;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire)
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RESET;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven check of mc_ctrl_fsm (TIMEOUT=4, CNT_W=4).
// Per-cycle vectors hold inputs plus expected controls/state/retired; each is
// pushed to a scoreboard when driven and popped when outputs are sampled.
module tb_mc_ctrl_fsm;
    import mips_mc_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       bus_err;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        string      nm;
        logic       r;
        logic [5:0] op;
        logic       z;
        logic       rdy;
        ctl_t       ctl;
        logic [3:0] st;
        logic [3:0] ret;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, bus_err, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] retired, state;

    int   errors = 0;
    int   checks = 0;
    int   ret_m  = 0;
    vec_t vecs[$];
    vec_t sb[$];

    mc_ctrl_fsm #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .bus_err(bus_err),
        .illegal_op(illegal_op), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected control words per state, written out from the port table.
    function automatic ctl_t c_fetch(input logic rdy, input logic be);
        c_fetch = '0; c_fetch.mem_read = 1; c_fetch.alu_src_b = 2'b01;
        c_fetch.ir_write = rdy; c_fetch.pc_en = rdy; c_fetch.bus_err = be;
    endfunction
    function automatic ctl_t c_dec(input logic ill);
        c_dec = '0; c_dec.alu_src_b = 2'b11; c_dec.illegal_op = ill;
    endfunction
    function automatic ctl_t c_memadr();
        c_memadr = '0; c_memadr.alu_src_a = 1; c_memadr.alu_src_b = 2'b10;
    endfunction
    function automatic ctl_t c_memrd(input logic be);
        c_memrd = '0; c_memrd.iord = 1; c_memrd.mem_read = 1; c_memrd.bus_err = be;
    endfunction
    function automatic ctl_t c_memwb();
        c_memwb = '0; c_memwb.mem_to_reg = 1; c_memwb.reg_write = 1;
    endfunction
    function automatic ctl_t c_memwr();
        c_memwr = '0; c_memwr.iord = 1; c_memwr.mem_write = 1;
    endfunction
    function automatic ctl_t c_exec();
        c_exec = '0; c_exec.alu_src_a = 1; c_exec.alu_op = 2'b10;
    endfunction
    function automatic ctl_t c_aluwb();
        c_aluwb = '0; c_aluwb.reg_dst = 1; c_aluwb.reg_write = 1;
    endfunction
    function automatic ctl_t c_branch(input logic pe);
        c_branch = '0; c_branch.alu_src_a = 1; c_branch.alu_op = 2'b01;
        c_branch.pc_src = 2'b01; c_branch.pc_en = pe;
    endfunction
    function automatic ctl_t c_immex(input logic [1:0] aop);
        c_immex = '0; c_immex.alu_src_a = 1; c_immex.alu_src_b = 2'b10; c_immex.alu_op = aop;
    endfunction
    function automatic ctl_t c_immwb();
        c_immwb = '0; c_immwb.reg_write = 1;
    endfunction
    function automatic ctl_t c_jump();
        c_jump = '0; c_jump.pc_src = 2'b10; c_jump.pc_en = 1;
    endfunction

    task automatic add(input string nm, input logic r, input logic [5:0] op,
                       input logic z, input logic rdy, input ctl_t c, input state_t st);
        vec_t v;
        v.nm = nm; v.r = r; v.op = op; v.z = z; v.rdy = rdy;
        v.ctl = c; v.st = st; v.ret = 4'(ret_m);
        vecs.push_back(v);
    endtask

    task automatic retire_m();
        ret_m = (ret_m + 1) % 16;
    endtask

    task automatic b_fd(input string nm, input logic [5:0] op, input logic ill);
        add({nm, "_fetch"}, 1, op, 0, 1, c_fetch(1, 0), S_FETCH);
        add({nm, "_decode"}, 1, op, 0, 1, c_dec(ill), S_DECODE);
    endtask

    // Fetch and sample combinational outputs for one driven vector.
    task automatic check_now();
        vec_t e;
        ctl_t a;
        e = sb.pop_front();
        a = '{pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
              mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, bus_err, illegal_op};
        checks++;
        if (a !== e.ctl || state !== e.st || retired !== e.ret) begin
            errors++;
            $display("FAIL %s: got ctl=%b state=%0d retired=%0d, want ctl=%b state=%0d retired=%0d",
                     e.nm, a, state, retired, e.ctl, e.st, e.ret);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.r; opcode = v.op; zero = v.z; mem_ready = v.rdy;
        sb.push_back(v);
        #1;
        check_now();
    endtask

    initial begin
        vec_t v;
        // ---- build the vector table ----
        add("reset_hold", 0, 0, 0, 1, '0, S_RESET);
        add("reset_release", 1, 0, 0, 1, '0, S_RESET);
        // R-type, zero-wait: 4 cycles
        b_fd("r", OP_RTYPE, 0);
        add("r_exec", 1, OP_RTYPE, 0, 1, c_exec(), S_EXEC);
        add("r_aluwb", 1, OP_RTYPE, 0, 1, c_aluwb(), S_ALUWB); retire_m();
        // lw with 3 wait cycles; ready arrives in the would-be timeout cycle
        b_fd("lw", OP_LW, 0);
        add("lw_memadr", 1, OP_LW, 0, 1, c_memadr(), S_MEMADR);
        for (int i = 0; i < 3; i++) add("lw_memrd_wait", 1, OP_LW, 0, 0, c_memrd(0), S_MEMRD);
        add("lw_memrd_done", 1, OP_LW, 0, 1, c_memrd(0), S_MEMRD);
        add("lw_memwb", 1, OP_LW, 0, 0, c_memwb(), S_MEMWB); retire_m();
        // branches, all four zero/opcode combinations
        b_fd("beq1", OP_BEQ, 0); add("beq_z1", 1, OP_BEQ, 1, 0, c_branch(1), S_BRANCH); retire_m();
        b_fd("bne1", OP_BNE, 0); add("bne_z1", 1, OP_BNE, 1, 0, c_branch(0), S_BRANCH); retire_m();
        b_fd("beq0", OP_BEQ, 0); add("beq_z0", 1, OP_BEQ, 0, 0, c_branch(0), S_BRANCH); retire_m();
        b_fd("bne0", OP_BNE, 0); add("bne_z0", 1, OP_BNE, 0, 0, c_branch(1), S_BRANCH); retire_m();
        // sw
        b_fd("sw", OP_SW, 0);
        add("sw_memadr", 1, OP_SW, 0, 1, c_memadr(), S_MEMADR);
        add("sw_memwr", 1, OP_SW, 0, 1, c_memwr(), S_MEMWR); retire_m();
        // addi / ori
        b_fd("addi", OP_ADDI, 0);
        add("addi_immex", 1, OP_ADDI, 0, 1, c_immex(2'b00), S_IMMEX);
        add("addi_immwb", 1, OP_ADDI, 0, 1, c_immwb(), S_IMMWB); retire_m();
        b_fd("ori", OP_ORI, 0);
        add("ori_immex", 1, OP_ORI, 0, 1, c_immex(2'b11), S_IMMEX);
        add("ori_immwb", 1, OP_ORI, 0, 1, c_immwb(), S_IMMWB); retire_m();
        // fetch timeout: bus_err on the 4th waiting cycle, then refetch
        for (int i = 0; i < 3; i++) add("fetch_wait", 1, OP_J, 0, 0, c_fetch(0, 0), S_FETCH);
        add("fetch_timeout", 1, OP_J, 0, 0, c_fetch(0, 1), S_FETCH);
        // illegal opcode
        b_fd("illegal", 6'b111111, 1);
        // memory-read timeout
        b_fd("lwto", OP_LW, 0);
        add("lwto_memadr", 1, OP_LW, 0, 0, c_memadr(), S_MEMADR);
        for (int i = 0; i < 3; i++) add("lwto_wait", 1, OP_LW, 0, 0, c_memrd(0), S_MEMRD);
        add("lwto_timeout", 1, OP_LW, 0, 0, c_memrd(1), S_MEMRD);
        // jumps: 8 retires take the 4-bit counter 9 -> 0 -> 1
        for (int k = 0; k < 8; k++) begin
            b_fd("j", OP_J, 0);
            add("j_jump", 1, OP_J, 0, 1, c_jump(), S_JUMP); retire_m();
        end
        add("after_wrap", 1, OP_LW, 0, 1, c_fetch(1, 0), S_FETCH);
        add("lwr_decode", 1, OP_LW, 0, 1, c_dec(0), S_DECODE);
        add("lwr_memadr", 1, OP_LW, 0, 1, c_memadr(), S_MEMADR);
        add("lwr_memrd", 1, OP_LW, 0, 0, c_memrd(0), S_MEMRD);

        // ---- apply table ----
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // ---- async reset in the middle of a MEMRD wait ----
        #2;
        rst = 1'b0;
        v.nm = "async_reset"; v.r = 0; v.op = OP_LW; v.z = 0; v.rdy = 0;
        v.ctl = '0; v.st = S_RESET; v.ret = 4'd0;
        sb.push_back(v);
        #1;
        check_now();
        v.nm = "reset_held"; apply(v);
        v.nm = "release"; v.r = 1; v.rdy = 1; apply(v);
        v.nm = "post_reset_fetch"; v.op = OP_RTYPE; v.ctl = c_fetch(1, 0); v.st = S_FETCH;
        apply(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
